dfr_output_capture: RTL and testbench

DFR_OUTPUT_CAPTURE -- requirements
Module: dfr_output_capture

---
 rtl/dfr_output_capture_if.sv | 32 +++
 rtl/dfr_output_capture.sv | 151 +++++++++++++++
 tb/tb_dfr_output_capture.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dfr_output_capture_if.sv
// rtl/dfr_output_capture_if.sv - reservoir result stream and output RAM write port bundle
// Purpose: groups the reservoir result strobe/data and the output RAM write
//          port so the capture block and its environment share one bundle.
// Ports:
//   dfr_done       reservoir result-valid strobe, one sample per high cycle
//   dfr_returndata signed reservoir sample, valid with dfr_done
//   ram_grant      output RAM write port available this cycle
//   ram_wen        registered RAM write enable
//   ram_addr       registered RAM write address
//   ram_wdata      registered RAM write data (sign-extended sample)
// Modports: master = capture block (drives the RAM port), slave = environment.
interface dfr_output_capture_if #(
   parameter int DATA_W = 26,
   parameter int ADDR_W = 13
);
   logic              dfr_done;
   logic [DATA_W-1:0] dfr_returndata;
   logic              ram_grant;
   logic              ram_wen;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;

   modport master (
      input  dfr_done, dfr_returndata, ram_grant,
      output ram_wen, ram_addr, ram_wdata
   );

   modport slave (
      output dfr_done, dfr_returndata, ram_grant,
      input  ram_wen, ram_addr, ram_wdata
   );
endinterface

// File: rtl/dfr_output_capture.sv
// rtl/dfr_output_capture.sv - captures reservoir outputs through a skid FIFO into the output RAM
// Purpose: on start, accepts cfg_num_samples reservoir results, buffers them in
//          a small FIFO and writes them sign-extended to consecutive RAM
//          addresses whenever the RAM port is granted.
// Ports:
//   clock, resetn    clock and asynchronous active-low reset
//   start            one-cycle pulse starting a run (ignored while busy)
//   cfg_num_samples  samples per run, latched on start
//   bus              reservoir stream in, RAM write port out (master modport)
//   busy             high in CAPTURE or DRAIN
//   capture_done     high in DONE
//   sample_count     samples accepted this run (written plus dropped)
//   overflow         sticky, a sample was dropped this run
module dfr_output_capture #(
   parameter int DATA_W     = 26,
   parameter int ADDR_W     = 13,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [31:0]            cfg_num_samples,
   dfr_output_capture_if.master   bus,
   output logic                   busy,
   output logic                   capture_done,
   output logic [31:0]            sample_count,
   output logic                   overflow
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       target_q, target_d;
   logic [31:0]       sample_count_q, sample_count_d;
   logic              overflow_q, overflow_d;
   logic              ram_wen_q, ram_wen_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]       ram_wdata_q, ram_wdata_d;
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_mem_d [FIFO_DEPTH];

   logic fifo_empty, fifo_full, in_run, pop, accept, push;

   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      in_run     = (state_q == CAPTURE) || (state_q == DRAIN);
      pop        = in_run && !fifo_empty && bus.ram_grant;
      accept     = (state_q == CAPTURE) && bus.dfr_done;
      // A full FIFO still takes the sample when a slot frees in the same cycle.
      push       = accept && (!fifo_full || pop);

      state_d        = state_q;
      target_d       = target_q;
      sample_count_d = sample_count_q;
      overflow_d     = overflow_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      fifo_mem_d     = fifo_mem_q;
      ram_wen_d      = pop;
      ram_wdata_d    = ram_wdata_q;
      // The address advances after each write so the next write lands one higher.
      ram_addr_d     = ram_wen_q ? ram_addr_q + ADDR_W'(1) : ram_addr_q;

      if (pop) begin
         ram_wdata_d = 32'($signed(fifo_mem_q[rd_ptr_q[PTR_W-1:0]]));
         rd_ptr_d    = rd_ptr_q + 1'b1;
      end
      if (push) begin
         fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = bus.dfr_returndata;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (accept) begin
         sample_count_d = sample_count_q + 32'd1;
         if (!push) begin
            overflow_d = 1'b1;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               target_d       = cfg_num_samples;
               sample_count_d = 32'd0;
               ram_addr_d     = '0;
               overflow_d     = 1'b0;
               wr_ptr_d       = '0;
               rd_ptr_d       = '0;
               state_d        = (cfg_num_samples == 32'd0) ? DONE : CAPTURE;
            end
         end
         CAPTURE: begin
            if (accept && (sample_count_q + 32'd1 == target_q)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty && !ram_wen_q) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q        <= IDLE;
         target_q       <= 32'd0;
         sample_count_q <= 32'd0;
         overflow_q     <= 1'b0;
         ram_wen_q      <= 1'b0;
         ram_addr_q     <= '0;
         ram_wdata_q    <= 32'd0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
      end else begin
         state_q        <= state_d;
         target_q       <= target_d;
         sample_count_q <= sample_count_d;
         overflow_q     <= overflow_d;
         ram_wen_q      <= ram_wen_d;
         ram_addr_q     <= ram_addr_d;
         ram_wdata_q    <= ram_wdata_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         fifo_mem_q     <= fifo_mem_d;
      end
   end

   assign bus.ram_wen   = ram_wen_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign busy          = (state_q == CAPTURE) || (state_q == DRAIN);
   assign capture_done  = (state_q == DONE);
   assign sample_count  = sample_count_q;
   assign overflow      = overflow_q;
endmodule

// File: tb/tb_dfr_output_capture.sv
// tb/tb_dfr_output_capture.sv - scoreboard bench for dfr_output_capture
module tb_dfr_output_capture;
   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [31:0] cfg = 32'd0;
   logic        busy, capture_done, overflow;
   logic [31:0] sample_count;

   dfr_output_capture_if #(.DATA_W(26), .ADDR_W(13)) bus ();

   dfr_output_capture #(.DATA_W(26), .ADDR_W(13), .FIFO_DEPTH(4)) dut (
      .clock           (clock),
      .resetn          (resetn),
      .start           (start),
      .cfg_num_samples (cfg),
      .bus             (bus.master),
      .busy            (busy),
      .capture_done    (capture_done),
      .sample_count    (sample_count),
      .overflow        (overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          due;
   } wr_t;

   int  tests = 0;
   int  fails = 0;
   int  tcyc  = 0;
   int  n_wr  = 0;
   wr_t exp_q[$];

   // Reference model: run phase, latched count, queue of buffered samples.
   localparam int P_IDLE = 0, P_CAP = 1, P_DRAIN = 2, P_DONE = 3;
   int m_phase = P_IDLE;
   int m_target = 0, m_count = 0, m_writes = 0, m_pushed = 0;
   bit m_ovf = 0, m_pend = 0;
   int fifo_m[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, tcyc);
      end
   endtask

   // Monitor: every RAM write must match the next expected write, in its cycle.
   always @(posedge clock) begin
      #2;
      if (resetn && bus.ram_wen === 1'b1) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", bus.ram_addr, bus.ram_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 64'(bus.ram_addr), 64'(e.addr));
            check("wr_data", 64'(bus.ram_wdata), 64'(e.data));
            check("wr_cycle", 64'(tcyc), 64'(e.due));
         end
      end
   end

   task automatic step(input bit st, input int c, input bit dd, input int data, input bit g);
      int old;
      bit pop;
      int v;
      old = m_phase;
      start = st;
      cfg = c;
      bus.dfr_done = dd;
      bus.dfr_returndata = 26'(data);
      bus.ram_grant = g;
      pop = (old == P_CAP || old == P_DRAIN) && fifo_m.size() > 0 && g;
      if (old == P_DRAIN && fifo_m.size() == 0 && !m_pend) m_phase = P_DONE;
      if (pop) begin
         v = fifo_m.pop_front();
         if (v >= 33554432) v = v - 67108864;
         exp_q.push_back('{m_writes % 8192, 32'(v), tcyc});
         m_writes++;
      end
      if (old == P_CAP && dd) begin
         m_count++;
         if (fifo_m.size() < 4) begin
            fifo_m.push_back(data & 32'h3FFFFFF);
            m_pushed++;
         end else begin
            m_ovf = 1;
         end
         if (m_count == m_target) m_phase = P_DRAIN;
      end
      if ((old == P_IDLE || old == P_DONE) && st) begin
         m_target = c;
         m_count = 0;
         m_writes = 0;
         m_pushed = 0;
         m_ovf = 0;
         fifo_m.delete();
         n_wr = 0;
         m_phase = (c == 0) ? P_DONE : P_CAP;
      end
      m_pend = pop;
      @(negedge clock);
      tcyc++;
      if (resetn) begin
         check("busy", 64'(busy), 64'(m_phase == P_CAP || m_phase == P_DRAIN));
         check("capture_done", 64'(capture_done), 64'(m_phase == P_DONE));
         check("sample_count", 64'(sample_count), 64'(m_count));
         check("overflow", 64'(overflow), 64'(m_ovf));
      end
   endtask

   task automatic check_reset_values();
      check("rst_ram_wen", 64'(bus.ram_wen), 64'd0);
      check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
      check("rst_ram_wdata", 64'(bus.ram_wdata), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_capture_done", 64'(capture_done), 64'd0);
      check("rst_sample_count", 64'(sample_count), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      m_phase = P_IDLE;
      m_count = 0;
      m_ovf = 0;
      m_writes = 0;
      m_pend = 0;
      fifo_m.delete();
      exp_q.delete();
      #1;
      check_reset_values();
      @(negedge clock);
      tcyc++;
      resetn = 1'b1;
   endtask

   task automatic finish_run(input string name);
      int k;
      k = 0;
      while (m_phase != P_DONE && k < 300) begin
         step(0, 0, 0, 0, 1);
         k++;
      end
      check({name, "_done"}, 64'(capture_done), 64'd1);
      check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
      check({name, "_writes"}, 64'(n_wr), 64'(m_pushed));
   endtask

   initial begin
      int c;
      bus.dfr_done = 1'b0;
      bus.dfr_returndata = '0;
      bus.ram_grant = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check_reset_values();
      resetn = 1'b1;
      step(0, 0, 0, 0, 0);

      // Three samples, sign extension of positive, all-ones and negative values.
      step(1, 3, 0, 0, 1);
      step(0, 0, 1, 32'h0000005, 1);
      step(0, 0, 1, 32'h3FFFFFF, 1);
      step(0, 0, 1, 32'h2000000, 1);
      finish_run("basic");
      check("basic_count", 64'(sample_count), 64'd3);
      check("basic_nwr", 64'(n_wr), 64'd3);

      // Eight back-to-back samples with the RAM blocked: four fit, four drop.
      step(1, 8, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1, int'($urandom), 0);
      check("ovf_flag", 64'(overflow), 64'd1);
      finish_run("ovf");
      check("ovf_nwr", 64'(n_wr), 64'd4);
      check("ovf_count", 64'(sample_count), 64'd8);

      // Zero-length run goes straight to DONE.
      step(1, 0, 0, 0, 1);
      check("zero_done", 64'(capture_done), 64'd1);
      step(0, 0, 1, 7, 1);
      step(0, 0, 0, 0, 1);
      check("zero_nwr", 64'(n_wr), 64'd0);

      // Start and extra samples while draining have no effect.
      step(1, 4, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, int'($urandom), 0);
      step(1, 7, 1, 123, 0);
      step(0, 0, 1, 456, 1);
      finish_run("drain_start");
      check("drain_start_nwr", 64'(n_wr), 64'd4);

      // Randomised runs.
      for (int r = 0; r < 12; r++) begin
         int k;
         c = int'($urandom_range(1, 24));
         step(1, c, 0, 0, $urandom_range(0, 1));
         k = 0;
         while (m_phase == P_CAP && k < 500) begin
            step(($urandom_range(0, 15) == 0), int'($urandom_range(0, 9)),
                 $urandom_range(0, 1), int'($urandom), ($urandom_range(0, 9) < 6));
            k++;
         end
         finish_run("rand");
      end

      // Reset mid-run discards buffered samples.
      step(1, 5, 0, 0, 0);
      step(0, 0, 1, 11, 0);
      step(0, 0, 1, 22, 0);
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 1, 33, 1);
      check_reset_values();
      check("rst_nwr", 64'(n_wr), 64'd0);
      step(1, 1, 0, 0, 1);
      step(0, 0, 1, 32'h1234567, 1);
      finish_run("after_rst");

      // Long run so the address wraps from 0x1FFF to 0.
      step(1, 8193, 0, 0, 1);
      for (int i = 0; i < 8193; i++) step(0, 0, 1, int'($urandom), 1);
      finish_run("wrap");
      check("wrap_nwr", 64'(n_wr), 64'd8193);
      check("wrap_ovf", 64'(overflow), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
